button_press_classifier: RTL and testbench

//  Consumes the debounced pushbutton level (debouncer output, e.g. btnCDeb) and classifies gestures.

---
 rtl/button_press_classifier.sv | 173 +++++++++++++++++
 tb/tb_button_press_classifier.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_press_classifier
// Description : Turns a debounced button level into press/release/short/long/
//               double (and optional auto-repeat) one-cycle pulses.
//               Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_press_classifier #(
    parameter int LONG_CYCLES    = 100_000_000,
    parameter int DBL_GAP_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_deb,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       repeat_pulse,
    output logic [2:0] state_o
);

    localparam int c_maxAB     = (LONG_CYCLES > DBL_GAP_CYCLES) ? LONG_CYCLES : DBL_GAP_CYCLES;
    localparam int c_maxCycles = (c_maxAB > REPEAT_CYCLES) ? c_maxAB : REPEAT_CYCLES;
    localparam int CNT_W       = $clog2(c_maxCycles) + 1;

    localparam logic [CNT_W-1:0] c_longLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gapLast  = CNT_W'(DBL_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cntOne   = CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_repLast  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT_DBL  = 3'd3,
        S_SECOND    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_btnQ;
    logic             w_rise;
    logic             w_fall;
    logic             w_short;
    logic             w_long;
    logic             w_double;
    logic             r_pressPulse;
    logic             r_releasePulse;
    logic             r_shortPress;
    logic             r_longPress;
    logic             r_doublePress;

    assign w_rise = btn_deb & ~r_btnQ;
    assign w_fall = ~btn_deb & r_btnQ;

`ifdef BTN_AUTOREPEAT_EN
    logic w_repeat;
    logic r_repeatPulse;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = '0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_double    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_repeat    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_stateNext = S_PRESSED;
                end
            end
            // A release on the same edge as the long limit takes the short path.
            S_PRESSED: begin
                if (w_fall) begin
                    w_stateNext = S_WAIT_DBL;
                end else if (r_cnt == c_longLast) begin
                    w_long      = 1'b1;
                    w_stateNext = S_LONG_HELD;
                end else begin
                    w_cntNext = r_cnt + c_cntOne;
                end
            end
            S_LONG_HELD: begin
                if (w_fall) begin
                    w_stateNext = S_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                end else if (r_cnt == c_repLast) begin
                    w_repeat = 1'b1;
                end else begin
                    w_cntNext = r_cnt + c_cntOne;
`endif
                end
            end
            // A re-press on the gap-expiry edge still counts as a double press.
            S_WAIT_DBL: begin
                if (w_rise) begin
                    w_double    = 1'b1;
                    w_stateNext = S_SECOND;
                end else if (r_cnt == c_gapLast) begin
                    w_short     = 1'b1;
                    w_stateNext = S_IDLE;
                end else begin
                    w_cntNext = r_cnt + c_cntOne;
                end
            end
            S_SECOND: begin
                if (w_fall) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_btnQ         <= 1'b0;
            r_pressPulse   <= 1'b0;
            r_releasePulse <= 1'b0;
            r_shortPress   <= 1'b0;
            r_longPress    <= 1'b0;
            r_doublePress  <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_cnt          <= w_cntNext;
            r_btnQ         <= btn_deb;
            r_pressPulse   <= w_rise;
            r_releasePulse <= w_fall;
            r_shortPress   <= w_short;
            r_longPress    <= w_long;
            r_doublePress  <= w_double;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repeatPulse <= 1'b0;
        end else begin
            r_repeatPulse <= w_repeat;
        end
    end
    assign repeat_pulse = r_repeatPulse;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press_pulse   = r_pressPulse;
    assign release_pulse = r_releasePulse;
    assign short_press   = r_shortPress;
    assign long_press    = r_longPress;
    assign double_press  = r_doublePress;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for button_press_classifier: gesture table, directed reset cases and
// randomized button activity checked against a timestamp-based gesture model.
module tb_button_press_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 8;
    localparam int REP  = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
    localparam int REPN    = 2;
`else
    localparam bit AUTOREP = 1'b0;
    localparam int REPN    = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_deb;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       repeat_pulse;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    button_press_classifier #(
        .LONG_CYCLES    (LONG),
        .DBL_GAP_CYCLES (GAP),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_deb       (btn_deb),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .double_press  (double_press),
        .repeat_pulse  (repeat_pulse),
        .state_o       (state_o)
    );

    int checks = 0;
    int errors = 0;

    // Gesture model: timestamps of press detect / release detect plus gesture phase.
    logic mPrev;
    bit   mFirst, mLong, mWait, mSecond;
    int   mTPress, mTRel, mEdge;

    // Pulse statistics; index 0 press,1 release,2 short,3 long,4 double,5 repeat.
    int pulseCnt [6];
    int firstAt  [6];

    task automatic modelReset();
        mPrev   = 1'b0;
        mFirst  = 0;
        mLong   = 0;
        mWait   = 0;
        mSecond = 0;
        mTPress = 0;
        mTRel   = 0;
        mEdge   = 0;
        for (int k = 0; k < 6; k++) begin
            pulseCnt[k] = 0;
            firstAt[k]  = -1;
        end
    endtask

    task automatic modelEdge(input logic b, output logic [5:0] p, output logic [2:0] st);
        logic rise, fall;
        rise = b & ~mPrev;
        fall = ~b & mPrev;
        p    = '0;
        p[5] = rise;
        p[4] = fall;
        if (mFirst) begin
            if (fall) begin
                mFirst = 0; mWait = 1; mTRel = mEdge;
            end else if (mEdge - mTPress == LONG) begin
                p[2] = 1'b1; mFirst = 0; mLong = 1;
            end
        end else if (mLong) begin
            if (fall) mLong = 0;
            else if (AUTOREP && ((mEdge - mTPress - LONG) % REP == 0)) p[0] = 1'b1;
        end else if (mWait) begin
            if (rise) begin
                p[1] = 1'b1; mWait = 0; mSecond = 1;
            end else if (mEdge - mTRel == GAP) begin
                p[3] = 1'b1; mWait = 0;
            end
        end else if (mSecond) begin
            if (fall) mSecond = 0;
        end else if (rise) begin
            mFirst = 1; mTPress = mEdge;
        end
        st    = mFirst ? 3'd1 : mLong ? 3'd2 : mWait ? 3'd3 : mSecond ? 3'd4 : 3'd0;
        mPrev = b;
    endtask

    function automatic logic [5:0] observed();
        return {press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse};
    endfunction

    task automatic checkInt(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, got, exp);
        end
    endtask

    task automatic checkZero(input string name);
        checks++;
        if (observed() !== 6'b0 || state_o !== 3'd0) begin
            errors++;
            $display("FAIL %s: actual pulses %b state %0d required 000000 state 0",
                     name, observed(), state_o);
        end
    endtask

    task automatic step(input logic b);
        logic [5:0] ep;
        logic [2:0] es;
        logic [5:0] got;
        btn_deb = b;
        @(posedge clk);
        modelEdge(b, ep, es);
        #1;
        got = observed();
        checks++;
        if (got !== ep || state_o !== es) begin
            errors++;
            $display("FAIL step %0d pulses/state: actual %b/%0d required %b/%0d",
                     mEdge, got, state_o, ep, es);
        end
        for (int k = 0; k < 6; k++) begin
            if (got[5-k] === 1'b1) begin
                pulseCnt[k]++;
                if (firstAt[k] < 0) firstAt[k] = mEdge;
            end
        end
        mEdge++;
    endtask

    task automatic doReset(input logic b);
        rst_n   = 1'b0;
        btn_deb = b;
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset state");
        rst_n = 1'b1;
        modelReset();
    endtask

    typedef struct {
        int h1, l1, h2, l2, h3;
        int nPress, nRel, nShort, nLong, nDbl, nRep;
        int shortDelay, longDelay;
    } scen_t;

    scen_t scen [8];
    string cntName [6] = '{"press count", "release count", "short count",
                           "long count", "double count", "repeat count"};

    initial begin
        int expN [6];
        logic lvl;
        int   len;

        scen[0] = '{5, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0,     8, -1};
        scen[1] = '{31, 0, 0, 0, 0,  1, 1, 0, 1, 0, REPN, -1, 20};
        scen[2] = '{3, 4, 3, 0, 0,   2, 2, 0, 0, 1, 0,    -1, -1};
        scen[3] = '{3, 8, 3, 0, 0,   2, 2, 0, 0, 1, 0,    -1, -1};
        scen[4] = '{3, 9, 3, 0, 0,   2, 2, 2, 0, 0, 0,     8, -1};
        scen[5] = '{20, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0,     8, -1};
        scen[6] = '{21, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0,    -1, 20};
        scen[7] = '{2, 2, 2, 2, 2,   3, 3, 1, 0, 1, 0,    -1, -1};

        rst_n   = 1'b0;
        btn_deb = 1'b0;
        modelReset();

        // Gesture table
        for (int s = 0; s < 8; s++) begin
            doReset(1'b0);
            repeat (scen[s].h1) step(1'b1);
            repeat (scen[s].l1) step(1'b0);
            repeat (scen[s].h2) step(1'b1);
            repeat (scen[s].l2) step(1'b0);
            repeat (scen[s].h3) step(1'b1);
            repeat (30) step(1'b0);
            expN = '{scen[s].nPress, scen[s].nRel, scen[s].nShort,
                     scen[s].nLong, scen[s].nDbl, scen[s].nRep};
            for (int k = 0; k < 6; k++)
                checkInt($sformatf("scenario %0d %s", s, cntName[k]), pulseCnt[k], expN[k]);
            if (scen[s].shortDelay >= 0)
                checkInt($sformatf("scenario %0d short delay", s),
                         firstAt[2] - firstAt[1], scen[s].shortDelay);
            if (scen[s].longDelay >= 0)
                checkInt($sformatf("scenario %0d long delay", s),
                         firstAt[3] - firstAt[0], scen[s].longDelay);
        end

        // Asynchronous reset in the middle of a press, button kept held through release
        doReset(1'b0);
        repeat (4) step(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async reset mid-press");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        repeat (25) step(1'b1);
        checkInt("held-through-reset press count", pulseCnt[0], 1);
        checkInt("held-through-reset press edge", firstAt[0], 0);
        checkInt("held-through-reset long count", pulseCnt[3], 1);
        checkInt("held-through-reset long delay", firstAt[3] - firstAt[0], LONG);

        // Randomized button activity with occasional resets
        doReset(1'b0);
        lvl = 1'b0;
        for (int seg = 0; seg < 220; seg++) begin
            if ($urandom_range(0, 39) == 0) doReset(lvl);
            lvl = ~lvl;
            len = $urandom_range(1, 26);
            repeat (len) step(lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
